dma_rd_data_mux: RTL and testbench

Read-side counterpart of the DMA write data mux. It sits between the DMA engine's segmented RAM read port (the port used for host writes) and two local RAM clients: CU (tag 0) and RE (tag 1). Each read command is steered to the client named by the tag of the descriptor currently in progress. Each segment's read responses are returned to the DMA engine in command order, whatever the two clients' latencies.

---
 rtl/dma_rd_data_mux.sv | 113 +++++++++++
 tb/tb_dma_rd_data_mux.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rd_data_mux.sv
// dma_rd_data_mux: steers DMA RAM reads to CU/RE by descriptor tag and returns responses in command order per segment
module dma_rd_data_mux #(
  parameter int RAM_ADDR_WIDTH = 15,
  parameter int RAM_SEG_COUNT = 2,
  parameter int RAM_SEG_DATA_WIDTH = 256,
  parameter int RAM_SEG_ADDR_WIDTH = RAM_ADDR_WIDTH - $clog2(RAM_SEG_COUNT * RAM_SEG_DATA_WIDTH / 8),
  parameter int TAG_FIFO_DEPTH = 32,
  parameter int OUT_FIFO_DEPTH = 16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         desc_tag,
  input  logic                                         desc_valid,
  input  logic                                         desc_ready,
  input  logic                                         desc_status_valid,
  input  logic [RAM_SEG_COUNT*RAM_SEG_ADDR_WIDTH-1:0]  dma_ram_rd_cmd_addr,
  input  logic [RAM_SEG_COUNT-1:0]                     dma_ram_rd_cmd_valid,
  output logic [RAM_SEG_COUNT-1:0]                     dma_ram_rd_cmd_ready,
  output logic [RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH-1:0]  dma_ram_rd_resp_data,
  output logic [RAM_SEG_COUNT-1:0]                     dma_ram_rd_resp_valid,
  input  logic [RAM_SEG_COUNT-1:0]                     dma_ram_rd_resp_ready,
  output logic [RAM_SEG_COUNT*RAM_SEG_ADDR_WIDTH-1:0]  cu_dma_ram_rd_cmd_addr,
  output logic [RAM_SEG_COUNT-1:0]                     cu_dma_ram_rd_cmd_valid,
  input  logic [RAM_SEG_COUNT-1:0]                     cu_dma_ram_rd_cmd_ready,
  input  logic [RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH-1:0]  cu_dma_ram_rd_resp_data,
  input  logic [RAM_SEG_COUNT-1:0]                     cu_dma_ram_rd_resp_valid,
  output logic [RAM_SEG_COUNT-1:0]                     cu_dma_ram_rd_resp_ready,
  output logic [RAM_SEG_COUNT*RAM_SEG_ADDR_WIDTH-1:0]  re_dma_ram_rd_cmd_addr,
  output logic [RAM_SEG_COUNT-1:0]                     re_dma_ram_rd_cmd_valid,
  input  logic [RAM_SEG_COUNT-1:0]                     re_dma_ram_rd_cmd_ready,
  input  logic [RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH-1:0]  re_dma_ram_rd_resp_data,
  input  logic [RAM_SEG_COUNT-1:0]                     re_dma_ram_rd_resp_valid,
  output logic [RAM_SEG_COUNT-1:0]                     re_dma_ram_rd_resp_ready,
  output logic                                         tag_err
);
  localparam int SEG = RAM_SEG_COUNT;
  localparam int DW = RAM_SEG_DATA_WIDTH;
  localparam int TP = $clog2(TAG_FIFO_DEPTH);
  localparam int OP = $clog2(OUT_FIFO_DEPTH);
  logic [TAG_FIFO_DEPTH-1:0] tag_mem;
  logic [TP:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic tag_err_q, tag_err_d;
  logic tag_push, tag_push_ok, tag_pop, tag_empty, tag_full, sel;
  logic [SEG-1:0][OUT_FIFO_DEPTH-1:0] out_mem;
  logic [SEG-1:0][OP:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [SEG-1:0] out_empty, out_full, out_push, out_pop, src, cmd_ok;
  assign cu_dma_ram_rd_cmd_addr = dma_ram_rd_cmd_addr;
  assign re_dma_ram_rd_cmd_addr = dma_ram_rd_cmd_addr;
  assign tag_err = tag_err_q;
  always_comb begin
    tag_push = desc_valid && desc_ready;
    tag_empty = tag_wr_q == tag_rd_q;
    tag_full = tag_wr_q == {~tag_rd_q[TP], tag_rd_q[TP-1:0]};
    tag_pop = desc_status_valid && !tag_empty;
    tag_push_ok = tag_push && (!tag_full || tag_pop);
    tag_wr_d = tag_wr_q + {{TP{1'b0}}, tag_push_ok};
    tag_rd_d = tag_rd_q + {{TP{1'b0}}, tag_pop};
    tag_err_d = tag_err_q || (tag_push && !tag_push_ok) || (desc_status_valid && tag_empty);
    sel = tag_mem[tag_rd_q[TP-1:0]];
    out_empty = '0;
    out_full = '0;
    out_push = '0;
    out_pop = '0;
    src = '0;
    cmd_ok = '0;
    out_wr_d = out_wr_q;
    out_rd_d = out_rd_q;
    cu_dma_ram_rd_cmd_valid = '0;
    re_dma_ram_rd_cmd_valid = '0;
    dma_ram_rd_cmd_ready = '0;
    dma_ram_rd_resp_valid = '0;
    dma_ram_rd_resp_data = '0;
    cu_dma_ram_rd_resp_ready = '0;
    re_dma_ram_rd_resp_ready = '0;
    for (int i = 0; i < SEG; i++) begin
      out_empty[i] = out_wr_q[i] == out_rd_q[i];
      out_full[i] = out_wr_q[i] == {~out_rd_q[i][OP], out_rd_q[i][OP-1:0]};
      src[i] = out_mem[i][out_rd_q[i][OP-1:0]];
      cmd_ok[i] = !tag_empty && !out_full[i];
      cu_dma_ram_rd_cmd_valid[i] = dma_ram_rd_cmd_valid[i] && cmd_ok[i] && !sel;
      re_dma_ram_rd_cmd_valid[i] = dma_ram_rd_cmd_valid[i] && cmd_ok[i] && sel;
      dma_ram_rd_cmd_ready[i] = cmd_ok[i] && (sel ? re_dma_ram_rd_cmd_ready[i] : cu_dma_ram_rd_cmd_ready[i]);
      out_push[i] = dma_ram_rd_cmd_valid[i] && dma_ram_rd_cmd_ready[i];
      dma_ram_rd_resp_valid[i] = !out_empty[i] && (src[i] ? re_dma_ram_rd_resp_valid[i] : cu_dma_ram_rd_resp_valid[i]);
      dma_ram_rd_resp_data[i*DW +: DW] = out_empty[i] ? '0 : src[i] ? re_dma_ram_rd_resp_data[i*DW +: DW] : cu_dma_ram_rd_resp_data[i*DW +: DW];
      cu_dma_ram_rd_resp_ready[i] = dma_ram_rd_resp_ready[i] && !out_empty[i] && !src[i];
      re_dma_ram_rd_resp_ready[i] = dma_ram_rd_resp_ready[i] && !out_empty[i] && src[i];
      out_pop[i] = dma_ram_rd_resp_valid[i] && dma_ram_rd_resp_ready[i];
      out_wr_d[i] = out_wr_q[i] + {{OP{1'b0}}, out_push[i]};
      out_rd_d[i] = out_rd_q[i] + {{OP{1'b0}}, out_pop[i]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      tag_err_q <= 1'b0;
      out_wr_q <= '0;
      out_rd_q <= '0;
    end else begin
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      tag_err_q <= tag_err_d;
      out_wr_q <= out_wr_d;
      out_rd_q <= out_rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (tag_push_ok) tag_mem[tag_wr_q[TP-1:0]] <= desc_tag;
    for (int i = 0; i < SEG; i++)
      if (out_push[i]) out_mem[i][out_wr_q[i][OP-1:0]] <= sel;
  end
endmodule

// File: tb/tb_dma_rd_data_mux.sv
// tb_dma_rd_data_mux: directed self-checking bench for dma_rd_data_mux
module tb_dma_rd_data_mux;
  localparam int SEG = 2;
  localparam int AW = 9;
  localparam int DW = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic desc_tag, desc_valid, desc_ready, desc_status_valid;
  logic [SEG*AW-1:0] dma_addr, cu_addr, re_addr;
  logic [SEG-1:0] dma_cmd_valid, dma_cmd_ready, dma_resp_valid, dma_resp_ready;
  logic [SEG*DW-1:0] dma_resp_data, cu_resp_data, re_resp_data;
  logic [SEG-1:0] cu_cmd_valid, cu_cmd_ready, cu_resp_valid, cu_resp_ready;
  logic [SEG-1:0] re_cmd_valid, re_cmd_ready, re_resp_valid, re_resp_ready;
  logic tag_err;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  dma_rd_data_mux dut (
    .clk(clk), .rst_n(rst_n),
    .desc_tag(desc_tag), .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_status_valid(desc_status_valid),
    .dma_ram_rd_cmd_addr(dma_addr), .dma_ram_rd_cmd_valid(dma_cmd_valid), .dma_ram_rd_cmd_ready(dma_cmd_ready),
    .dma_ram_rd_resp_data(dma_resp_data), .dma_ram_rd_resp_valid(dma_resp_valid), .dma_ram_rd_resp_ready(dma_resp_ready),
    .cu_dma_ram_rd_cmd_addr(cu_addr), .cu_dma_ram_rd_cmd_valid(cu_cmd_valid), .cu_dma_ram_rd_cmd_ready(cu_cmd_ready),
    .cu_dma_ram_rd_resp_data(cu_resp_data), .cu_dma_ram_rd_resp_valid(cu_resp_valid), .cu_dma_ram_rd_resp_ready(cu_resp_ready),
    .re_dma_ram_rd_cmd_addr(re_addr), .re_dma_ram_rd_cmd_valid(re_cmd_valid), .re_dma_ram_rd_cmd_ready(re_cmd_ready),
    .re_dma_ram_rd_resp_data(re_resp_data), .re_dma_ram_rd_resp_valid(re_resp_valid), .re_dma_ram_rd_resp_ready(re_resp_ready),
    .tag_err(tag_err)
  );
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_tag(input logic t);
    desc_valid = 1'b1;
    desc_tag = t;
    tick();
    desc_valid = 1'b0;
  endtask
  task automatic status_pulse;
    desc_status_valid = 1'b1;
    tick();
    desc_status_valid = 1'b0;
  endtask
  initial begin
    desc_tag = 0; desc_valid = 0; desc_ready = 1; desc_status_valid = 0;
    dma_addr = '0; dma_cmd_valid = 2'b11; dma_resp_ready = 2'b11;
    cu_cmd_ready = 2'b11; re_cmd_ready = 2'b11;
    cu_resp_valid = 2'b11; re_resp_valid = 2'b11;
    cu_resp_data = '1; re_resp_data = '1;
    #2 rst_n = 1'b0;
    #1;
    check("rst cmd_ready", dma_cmd_ready, 0);
    check("rst resp_valid", dma_resp_valid, 0);
    check("rst resp_data0", dma_resp_data[DW-1:0], 0);
    check("rst resp_data1", dma_resp_data[2*DW-1:DW], 0);
    check("rst cu_cmd_valid", cu_cmd_valid, 0);
    check("rst re_cmd_valid", re_cmd_valid, 0);
    check("rst cu_resp_ready", cu_resp_ready, 0);
    check("rst re_resp_ready", re_resp_ready, 0);
    check("rst tag_err", tag_err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    cu_resp_valid = 0; re_resp_valid = 0; dma_cmd_valid = 2'b01;
    tick();
    check("empty cmd_ready", dma_cmd_ready, 0);
    check("empty cu_valid", cu_cmd_valid, 0);
    check("empty re_valid", re_cmd_valid, 0);
    desc_valid = 1'b1;
    #1 check("push same-cycle ready", dma_cmd_ready, 0);
    push_tag(1'b0);
    for (int k = 0; k < 4; k++) begin
      dma_addr = '0;
      dma_addr[AW-1:0] = AW'(k);
      #1;
      check("cu1 cu_valid", cu_cmd_valid, 2'b01);
      check("cu1 re_valid", re_cmd_valid, 0);
      check("cu1 cmd_ready", dma_cmd_ready, 2'b11);
      check("cu1 cu_addr", cu_addr[AW-1:0], k);
      tick();
    end
    dma_cmd_valid = 0;
    cu_resp_valid = 2'b01; re_resp_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      cu_resp_data = '0;
      cu_resp_data[DW-1:0] = DW'('hD0 + k);
      #1;
      check("cu1 resp_valid", dma_resp_valid, 2'b01);
      check("cu1 resp_data", dma_resp_data[DW-1:0], 'hD0 + k);
      check("cu1 cu_resp_ready", cu_resp_ready, 2'b01);
      check("cu1 re_resp_ready", re_resp_ready, 0);
      tick();
    end
    check("cu1 drained", dma_resp_valid, 0);
    cu_resp_valid = 0; re_resp_valid = 0;
    status_pulse();
    dma_cmd_valid = 2'b01;
    #1;
    check("cu1 tag popped", dma_cmd_ready, 0);
    check("cu1 tag_err", tag_err, 0);
    dma_cmd_valid = 0;
    push_tag(1'b0);
    push_tag(1'b1);
    dma_cmd_valid = 2'b10;
    #1;
    check("alt sel0 cu_valid", cu_cmd_valid, 2'b10);
    check("alt sel0 re_valid", re_cmd_valid, 0);
    tick();
    dma_cmd_valid = 0;
    status_pulse();
    dma_cmd_valid = 2'b10;
    #1;
    check("alt sel1 re_valid", re_cmd_valid, 2'b10);
    check("alt sel1 cu_valid", cu_cmd_valid, 0);
    tick();
    dma_cmd_valid = 0;
    re_resp_valid = 2'b10;
    re_resp_data = '0;
    re_resp_data[2*DW-1:DW] = DW'('hBEEF);
    #1;
    check("ooo re held valid", dma_resp_valid, 0);
    check("ooo re held ready", re_resp_ready, 0);
    tick();
    tick();
    cu_resp_valid = 2'b10;
    cu_resp_data = '0;
    cu_resp_data[2*DW-1:DW] = DW'('hCAFE);
    #1;
    check("ooo cu valid", dma_resp_valid, 2'b10);
    check("ooo cu data", dma_resp_data[2*DW-1:DW], 'hCAFE);
    check("ooo cu ready", cu_resp_ready, 2'b10);
    check("ooo re still held", re_resp_ready, 0);
    tick();
    cu_resp_valid = 0;
    #1;
    check("ooo re valid", dma_resp_valid, 2'b10);
    check("ooo re data", dma_resp_data[2*DW-1:DW], 'hBEEF);
    check("ooo re ready", re_resp_ready, 2'b10);
    tick();
    re_resp_valid = 0;
    status_pulse();
    push_tag(1'b0);
    dma_resp_ready = 0;
    cu_resp_valid = 2'b01;
    dma_cmd_valid = 2'b01;
    for (int k = 0; k < 16; k++) begin
      #1 check("bp accept", dma_cmd_ready[0], 1);
      tick();
    end
    check("bp full ready", dma_cmd_ready, 2'b10);
    check("bp full cu_valid", cu_cmd_valid, 0);
    repeat (20) tick();
    check("bp stalled ready", dma_cmd_ready, 2'b10);
    check("bp stalled resp", dma_resp_valid, 2'b01);
    dma_resp_ready = 2'b01;
    #1 check("bp pop cycle", dma_cmd_ready, 2'b10);
    tick();
    dma_resp_ready = 0;
    check("bp resumed", dma_cmd_ready, 2'b11);
    tick();
    dma_cmd_valid = 0;
    dma_resp_ready = 2'b01;
    repeat (16) tick();
    check("bp drained", dma_resp_valid, 0);
    cu_resp_valid = 0;
    status_pulse();
    check("bp tag_err", tag_err, 0);
    status_pulse();
    check("underflow tag_err", tag_err, 1);
    repeat (3) tick();
    check("underflow sticky", tag_err, 1);
    rst_n = 1'b0;
    #1 check("async rst tag_err", tag_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    desc_valid = 1'b1;
    for (int k = 0; k < 33; k++) begin
      desc_tag = (k % 3 == 0);
      if (k == 32) begin
        #1 check("ovf before", tag_err, 0);
      end
      tick();
    end
    desc_valid = 0;
    check("ovf tag_err", tag_err, 1);
    cu_cmd_ready = 0; re_cmd_ready = 0;
    dma_cmd_valid = 2'b01;
    for (int k = 0; k < 32; k++) begin
      #1 check("ovf tag order", {re_cmd_valid[0], cu_cmd_valid[0]}, (k % 3 == 0) ? 2'b10 : 2'b01);
      status_pulse();
    end
    check("ovf 32 kept", {re_cmd_valid, cu_cmd_valid}, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    dma_cmd_valid = 0; cu_cmd_ready = 2'b11; re_cmd_ready = 2'b11;
    push_tag(1'b0);
    dma_cmd_valid = 2'b01;
    tick();
    cu_resp_valid = 2'b01; dma_resp_ready = 2'b01;
    #1;
    check("mid pre resp_valid", dma_resp_valid, 2'b01);
    check("mid pre cmd_ready", dma_cmd_ready, 2'b11);
    check("mid pre cu_resp_ready", cu_resp_ready, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    check("mid rst cmd_ready", dma_cmd_ready, 0);
    check("mid rst resp_valid", dma_resp_valid, 0);
    check("mid rst resp_data", dma_resp_data[DW-1:0], 0);
    check("mid rst cu_valid", cu_cmd_valid, 0);
    check("mid rst re_valid", re_cmd_valid, 0);
    check("mid rst cu_resp_ready", cu_resp_ready, 0);
    check("mid rst re_resp_ready", re_resp_ready, 0);
    check("mid rst tag_err", tag_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
